// File: rtl/video_mode_code_writer.sv
// Encodes resolution and input format into a 7-bit mode code.
// Each confirmed, stable change of that code is written as one byte into the reconfig FIFO.
module video_mode_code_writer #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_WIDTH     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] resolution,
  input  logic       is_240p,
  input  logic       is_interlaced,
  input  logic       is_pal,
  input  logic       force_resend,
  input  logic       wrfull,
  output logic       wrreq,
  output logic [7:0] wrdata,
  output logic [6:0] committed_code,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, STABLE, WAIT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [6:0]           cand_reg;
  logic [6:0]           prev_reg;
  logic                 force_pending_reg;
  logic [6:0]           code_next;

  // Interlace outranks 240p; PAL only qualifies interlaced input.
  always_comb begin
    code_next = {5'b00000, resolution};
    if (is_interlaced && is_pal)
      code_next = 7'h40 | {5'b00000, resolution};
    else if (is_interlaced)
      code_next = 7'h20 | {5'b00000, resolution};
    else if (is_240p)
      code_next = 7'h10 | {5'b00000, resolution};
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      cand_reg          <= 7'h7F;
      prev_reg          <= 7'h7F;
      force_pending_reg <= 1'b0;
      wrreq             <= 1'b0;
      wrdata            <= 8'h00;
      committed_code    <= 7'h7F;
    end else begin
      cand_reg <= code_next;
      prev_reg <= cand_reg;
      wrreq    <= 1'b0;
      if (force_resend)
        force_pending_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if ((cand_reg != committed_code) || force_pending_reg) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
          end
        end
        STABLE: begin
          // A code that falls back to the committed one was only a glitch.
          if ((cand_reg == committed_code) && !force_pending_reg)
            state_reg <= IDLE;
          else if (cand_reg != prev_reg)
            cnt_reg <= '0;
          else if (cnt_reg == CNT_LAST)
            state_reg <= WAIT;
          else
            cnt_reg <= cnt_reg + 1'b1;
        end
        WAIT: begin
          if (cand_reg != prev_reg) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
          end else if (!wrfull) begin
            wrreq             <= 1'b1;
            wrdata            <= {force_pending_reg, cand_reg};
            committed_code    <= cand_reg;
            // A resend request arriving with this write must survive it.
            force_pending_reg <= force_resend;
            state_reg         <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_mode_code_writer.sv
// Scoreboarded bench for video_mode_code_writer: a timestamp-based reference model
// predicts each FIFO write; a negedge monitor checks writes, committed code and busy.
module tb_video_mode_code_writer;

  localparam int S = 16;

  logic       clock;
  logic       reset;
  logic [1:0] resolution;
  logic       is_240p;
  logic       is_interlaced;
  logic       is_pal;
  logic       force_resend;
  logic       wrfull;
  logic       wrreq;
  logic [7:0] wrdata;
  logic [6:0] committed_code;
  logic       busy;

  video_mode_code_writer #(.STABLE_CYCLES(S), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .resolution(resolution), .is_240p(is_240p),
    .is_interlaced(is_interlaced), .is_pal(is_pal), .force_resend(force_resend),
    .wrfull(wrfull), .wrreq(wrreq), .wrdata(wrdata),
    .committed_code(committed_code), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         edge_no;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   started = 0;

  // Reference model state
  int       m_e = 0;
  int       m_base = 0;
  bit       m_busy = 0;
  bit       m_fp = 0;
  logic [6:0] m_committed = 7'h7F;
  logic [6:0] m_cand = 7'h7F;
  logic [6:0] m_prev = 7'h7F;

  function automatic logic [6:0] ref_code(input logic [1:0] res, input logic p240,
                                          input logic il, input logic pal);
    int v;
    v = int'(res);
    if (il && pal)   v = v + 64;
    else if (il)     v = v + 32;
    else if (p240)   v = v + 16;
    return 7'(v);
  endfunction

  // The model timestamps when the current candidate run began (m_base);
  // a write is due once the run has lasted S edges and the FIFO has room.
  always @(posedge clock) begin
    logic [6:0] c;
    logic [6:0] p;
    bit         wr;
    if (reset) begin
      m_e = 0; m_busy = 0; m_fp = 0;
      m_committed = 7'h7F; m_cand = 7'h7F; m_prev = 7'h7F;
      started = 1;
    end else begin
      c = m_cand;
      p = m_prev;
      m_e = m_e + 1;
      wr = 0;
      if (!m_busy) begin
        if (c != m_committed || m_fp) begin
          m_busy = 1;
          m_base = m_e;
        end
      end else if (m_e <= m_base + S && c == m_committed && !m_fp) begin
        m_busy = 0;
      end else if (c != p) begin
        m_base = m_e;
      end else if (m_e > m_base + S && !wrfull) begin
        wr = 1;
      end
      if (wr) begin
        exp_q.push_back('{edge_no: m_e, data: {m_fp, c}});
        m_committed = c;
        m_busy = 0;
        m_fp = force_resend;
      end else if (force_resend) begin
        m_fp = 1;
      end
      m_prev = c;
      m_cand = ref_code(resolution, is_240p, is_interlaced, is_pal);
    end
  end

  int   first_edge = -1;
  bit   first_seen = 0;
  logic wrreq_last = 1'b0;

  always @(negedge clock) begin
    exp_t it;
    if (started) begin
      if (reset) first_seen = 0;
      if (wrreq) begin
        if (!first_seen) begin
          first_seen = 1;
          first_edge = m_e;
        end
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_wrreq: edge %0d wrdata=%02h, required no write", m_e, wrdata);
        end else begin
          it = exp_q.pop_front();
          if (wrdata !== it.data || m_e != it.edge_no) begin
            tests_failed++;
            $display("FAIL write: got %02h at edge %0d, required %02h at edge %0d",
                     wrdata, m_e, it.data, it.edge_no);
          end
        end
        tests_run++;
        if (wrreq_last === 1'b1) begin
          tests_failed++;
          $display("FAIL back_to_back: wrreq=1 on two consecutive cycles, required single pulse");
        end
      end else if (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        tests_run++;
        tests_failed++;
        $display("FAIL missing_wrreq: wrreq=%b at edge %0d, required write of %02h",
                 wrreq, m_e, it.data);
      end
      tests_run++;
      if (committed_code !== m_committed) begin
        tests_failed++;
        $display("FAIL committed: got %02h, required %02h at edge %0d", committed_code, m_committed, m_e);
      end
      tests_run++;
      if (busy !== m_busy) begin
        tests_failed++;
        $display("FAIL busy: got %b, required %b at edge %0d", busy, m_busy, m_e);
      end
      wrreq_last = wrreq;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic set_in(input logic [1:0] r, input logic p240, input logic il, input logic pal);
    resolution = r; is_240p = p240; is_interlaced = il; is_pal = pal;
  endtask

  initial begin
    reset = 1'b1; force_resend = 1'b0; wrfull = 1'b0;
    set_in(2'd0, 1'b0, 1'b0, 1'b0);
    tick(3);
    // 1: first write after reset, constant inputs
    reset = 1'b0;
    tick(25);
    tests_run++;
    if (first_edge != S + 3) begin
      tests_failed++;
      $display("FAIL latency: first wrreq at edge %0d, required edge %0d", first_edge, S + 3);
    end
    // 2: 576i at 480p
    set_in(2'd2, 1'b0, 1'b1, 1'b1);
    tick(25);
    // 3: short 240p glitch on an already committed code
    set_in(2'd1, 1'b0, 1'b0, 1'b0);
    tick(25);
    is_240p = 1'b1;
    tick(5);
    is_240p = 1'b0;
    tick(25);
    // 4: FIFO full while 0x13 is pending
    wrfull = 1'b1;
    set_in(2'd3, 1'b1, 1'b0, 1'b0);
    tick(100);
    wrfull = 1'b0;
    tick(5);
    // 5: forced resend of unchanged 0x01
    set_in(2'd1, 1'b0, 1'b0, 1'b0);
    tick(25);
    force_resend = 1'b1;
    tick(1);
    force_resend = 1'b0;
    tick(25);
    // 6: reset while held in WAIT
    wrfull = 1'b1;
    set_in(2'd2, 1'b0, 1'b0, 1'b0);
    tick(25);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wrfull = 1'b0;
    tick(25);
    // Randomized traffic: slow input drift, FIFO back-pressure, resend pulses, rare resets
    for (int i = 0; i < 4000; i++) begin
      force_resend = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) wrfull = ~wrfull;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: resolution = 2'($urandom_range(0, 3));
          1: is_240p = ~is_240p;
          2: is_interlaced = ~is_interlaced;
          default: is_pal = ~is_pal;
        endcase
      end
      reset = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    reset = 1'b0; force_resend = 1'b0; wrfull = 1'b0;
    tick(40);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
